// File: rtl/simplebus_arbiter_pkg.sv
// Shared types and defaults for the Simplebus round-robin arbiter.
package simplebus_arbiter_pkg;

    localparam int SB_W = 32;

    // Read data handed back when the slave never answers.
    localparam logic [SB_W-1:0] TIMEOUT_DATA_DEFAULT = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    // One captured upstream request.
    typedef struct packed {
        logic [SB_W-1:0] addr;
        logic [SB_W-1:0] data;
        logic            is_write;
    } req_slot_t;

endpackage

// File: rtl/simplebus_arbiter_rr_select.sv
// Combinational round-robin selector: picks the first set request bit
// searching circularly from the slot after the last grant.
module rr_priority_select #(
    parameter int N     = 2,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_last,
    output logic [IDX_W-1:0] o_grant,
    output logic             o_any
);

    // Scan last+1 .. last+N (mod N); the first hit wins, so the last grant ranks lowest.
    always_comb begin
        logic w_found;
        int   w_idx;
        o_grant = '0;
        o_any   = |i_req;
        w_found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            w_idx = (int'(i_last) + k) % N;
            if (!w_found && i_req[w_idx]) begin
                o_grant = IDX_W'(w_idx);
                w_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/simplebus_arbiter.sv
// Round-robin arbiter sharing one Simplebus slave between N_MASTERS masters.
// Each master's request is captured into a private slot, then serialised
// downstream through an IDLE/ISSUE/WAIT/DONE sequence with a hang timeout.
module simplebus_arbiter
    import simplebus_arbiter_pkg::*;
#(
    parameter int          N_MASTERS      = 2,
    parameter int          TIMEOUT_CYCLES = 64,
    parameter logic [31:0] TIMEOUT_DATA   = TIMEOUT_DATA_DEFAULT
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [32*N_MASTERS-1:0]         m_sb_address,
    input  logic [N_MASTERS-1:0]            m_sb_read_strobe,
    input  logic [N_MASTERS-1:0]            m_sb_write_strobe,
    input  logic [32*N_MASTERS-1:0]         m_sb_write_data,
    output logic [32*N_MASTERS-1:0]         m_sb_read_data,
    output logic [N_MASTERS-1:0]            m_sb_ready,
    output logic [31:0]                     s_sb_address,
    output logic                            s_sb_read_strobe,
    output logic                            s_sb_write_strobe,
    output logic [31:0]                     s_sb_write_data,
    input  logic [31:0]                     s_sb_read_data,
    input  logic                            s_sb_ready,
    output logic                            timeout_error,
    output logic [$clog2(N_MASTERS)-1:0]    active_master
);

    localparam int IDX_W = $clog2(N_MASTERS);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    req_slot_t                          r_slot [N_MASTERS];
    logic [N_MASTERS-1:0]               r_pending;
    arb_state_t                         r_state;
    logic [IDX_W-1:0]                   r_active;
    logic [CNT_W-1:0]                   r_cnt;
    logic [31:0]                        r_rdata;
    logic [N_MASTERS-1:0][31:0]         r_rd_out;
    logic [31:0]                        r_s_addr;
    logic [31:0]                        r_s_wdata;
    logic                               r_s_rd;
    logic                               r_s_wr;
    logic                               r_timeout;

    logic [N_MASTERS-1:0]               w_accept;
    logic [N_MASTERS-1:0]               w_clr;
    logic [IDX_W-1:0]                   w_grant;
    logic                               w_any;
    req_slot_t                          w_sel;

    // A master may only hand over a new request while its slot is empty.
    assign m_sb_ready = ~r_pending;
    assign w_accept   = ~r_pending & (m_sb_read_strobe | m_sb_write_strobe);
    assign w_sel      = r_slot[w_grant];

    assign m_sb_read_data    = r_rd_out;
    assign s_sb_address      = r_s_addr;
    assign s_sb_write_data   = r_s_wdata;
    assign s_sb_read_strobe  = r_s_rd;
    assign s_sb_write_strobe = r_s_wr;
    assign timeout_error     = r_timeout;
    assign active_master     = r_active;

    rr_priority_select #(
        .N     (N_MASTERS),
        .IDX_W (IDX_W)
    ) u_rr (
        .i_req   (r_pending),
        .i_last  (r_active),
        .o_grant (w_grant),
        .o_any   (w_any)
    );

    // Release the served slot on the DONE cycle.
    always_comb begin
        w_clr = '0;
        if (r_state == DONE) w_clr[r_active] = 1'b1;
    end

    // Capture requests into slots; a write strobe wins over a simultaneous read.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pending <= '0;
            for (int i = 0; i < N_MASTERS; i++) r_slot[i] <= '0;
        end else begin
            for (int i = 0; i < N_MASTERS; i++) begin
                if (w_accept[i]) begin
                    r_slot[i].addr     <= m_sb_address[32*i +: 32];
                    r_slot[i].data     <= m_sb_write_data[32*i +: 32];
                    r_slot[i].is_write <= m_sb_write_strobe[i];
                    r_pending[i]       <= 1'b1;
                end else if (w_clr[i]) begin
                    r_pending[i]       <= 1'b0;
                end
            end
        end
    end

    // Arbitration FSM; all downstream outputs are registered here.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_active  <= IDX_W'(N_MASTERS - 1);
            r_cnt     <= '0;
            r_rdata   <= '0;
            r_rd_out  <= '0;
            r_s_addr  <= '0;
            r_s_wdata <= '0;
            r_s_rd    <= 1'b0;
            r_s_wr    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_timeout <= 1'b0;
                    if (w_any) begin
                        r_active  <= w_grant;
                        r_s_addr  <= w_sel.addr;
                        r_s_wdata <= w_sel.data;
                        r_s_wr    <= w_sel.is_write;
                        r_s_rd    <= ~w_sel.is_write;
                        r_state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Strobe lasts exactly this one cycle; slave ready is not looked at yet.
                    r_s_rd  <= 1'b0;
                    r_s_wr  <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (s_sb_ready) begin
                        r_rdata <= s_sb_read_data;
                        r_state <= DONE;
                    end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        r_rdata   <= TIMEOUT_DATA;
                        r_timeout <= 1'b1;
                        r_state   <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    r_timeout <= 1'b0;
                    if (!r_slot[r_active].is_write) r_rd_out[r_active] <= r_rdata;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_simplebus_arbiter.sv
// Scoreboard bench for simplebus_arbiter: expected downstream transactions
// and returned read data are queued at stimulus time, popped by monitors.
module tb_simplebus_arbiter;
    import simplebus_arbiter_pkg::*;

    localparam int          N  = 4;
    localparam int          TO = 20;
    localparam logic [31:0] HANG_ADDR = 32'hBAD0_0000;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [32*N-1:0]   m_addr = '0, m_wdata = '0, m_rdata;
    logic [N-1:0]      m_rs = '0, m_ws = '0, m_rdy;
    logic [31:0]       s_addr, s_wdata;
    logic [31:0]       s_rdata = '0;
    logic              s_rs, s_ws, tmo;
    logic              s_rdy = 1'b1;
    logic [1:0]        act;

    always #5 clock = ~clock;

    simplebus_arbiter #(
        .N_MASTERS      (N),
        .TIMEOUT_CYCLES (TO),
        .TIMEOUT_DATA   (32'hDEADBEEF)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .m_sb_address      (m_addr),
        .m_sb_read_strobe  (m_rs),
        .m_sb_write_strobe (m_ws),
        .m_sb_write_data   (m_wdata),
        .m_sb_read_data    (m_rdata),
        .m_sb_ready        (m_rdy),
        .s_sb_address      (s_addr),
        .s_sb_read_strobe  (s_rs),
        .s_sb_write_strobe (s_ws),
        .s_sb_write_data   (s_wdata),
        .s_sb_read_data    (s_rdata),
        .s_sb_ready        (s_rdy),
        .timeout_error     (tmo),
        .active_master     (act)
    );

    typedef struct {
        int          mst;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        bit          is_w;
    } exp_t;

    exp_t        sq[$];
    exp_t        cq[$];
    logic [31:0] wseq[$];
    int          gseq[$];
    int          total = 0;
    int          bad = 0;
    int          n_strobe = 0;
    int          n_tmo = 0;
    int          svc [N];
    logic [31:0] mdl_rd [N];
    int          slv_wait = 0;
    int          wcnt = 0;
    logic [N-1:0] prev_rdy = '1;

    function automatic logic [31:0] slv_data(logic [31:0] a);
        if (a == 32'h43C0_0004) return 32'h1234_5678;
        return a ^ 32'hA5A5_5A5A;
    endfunction

    // Slave model: answers each strobe after slv_wait cycles, never for HANG_ADDR.
    always @(negedge clock) begin
        if (!reset) begin
            s_rdy = 1'b1;
            wcnt  = 0;
        end else if (s_rs || s_ws) begin
            s_rdata = slv_data(s_addr);
            if (s_addr == HANG_ADDR) begin
                s_rdy = 1'b0;
                wcnt  = 1000000;
            end else if (slv_wait > 0) begin
                s_rdy = 1'b0;
                wcnt  = slv_wait;
            end else begin
                s_rdy = 1'b1;
            end
        end else if (!s_rdy) begin
            if (wcnt == 0) s_rdy = 1'b1;
            else wcnt--;
        end
    end

    // Monitor: downstream strobes against sq, ready rises against cq.
    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            if (s_rs || s_ws) begin
                n_strobe++;
                total++;
                wseq.push_back(s_wdata);
                gseq.push_back(int'(act));
                svc[act]++;
                if (sq.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_strobe addr=%h rs=%b ws=%b", s_addr, s_rs, s_ws);
                end else begin
                    e = sq.pop_front();
                    if (s_addr !== e.addr || s_ws !== e.is_w || s_rs !== !e.is_w ||
                        act !== 2'(e.mst) || (e.is_w && s_wdata !== e.wdata)) begin
                        bad++;
                        $display("FAIL downstream got addr=%h rs=%b ws=%b wd=%h act=%0d want addr=%h w=%b wd=%h act=%0d",
                                 s_addr, s_rs, s_ws, s_wdata, act, e.addr, e.is_w, e.wdata, e.mst);
                    end
                    cq.push_back(e);
                end
            end
            if (tmo) n_tmo++;
            for (int m = 0; m < N; m++) begin
                if (m_rdy[m] && !prev_rdy[m]) begin
                    total++;
                    if (cq.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_ready master=%0d", m);
                    end else begin
                        e = cq.pop_front();
                        if (e.mst != m || m_rdata[32*m +: 32] !== e.rdata) begin
                            bad++;
                            $display("FAIL completion got master=%0d rd=%h want master=%0d rd=%h",
                                     m, m_rdata[32*m +: 32], e.mst, e.rdata);
                        end
                    end
                end
            end
        end
        prev_rdy = m_rdy;
    end

    task automatic cyc(int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic strobe(int m, bit r, bit w, logic [31:0] a, logic [31:0] d);
        m_addr[32*m +: 32]  = a;
        m_wdata[32*m +: 32] = d;
        m_rs[m] = r;
        m_ws[m] = w;
    endtask

    task automatic push_exp(int m, logic [31:0] a, logic [31:0] d, bit w);
        exp_t e;
        e.mst = m; e.addr = a; e.wdata = d; e.is_w = w;
        if (!w) mdl_rd[m] = (a == HANG_ADDR) ? 32'hDEADBEEF : slv_data(a);
        e.rdata = mdl_rd[m];
        sq.push_back(e);
    endtask

    task automatic flush_model();
        sq.delete();
        cq.delete();
        for (int m = 0; m < N; m++) mdl_rd[m] = '0;
        m_rs = '0;
        m_ws = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        flush_model();
        cyc(2);
        reset = 1'b1;
        cyc(1);
    endtask

    task automatic wait_quiet(int bound, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < bound; c++) begin
            if (sq.size() == 0 && cq.size() == 0 && m_rdy == '1) begin
                ok = 1'b1;
                break;
            end
            cyc(1);
        end
    endtask

    // One read; lat = cycles from the strobe cycle to ready seen high (-1 if never).
    // A second strobe while busy must be dropped.
    task automatic do_read_lat(int m, logic [31:0] a, output int lat);
        push_exp(m, a, 32'h0, 1'b0);
        strobe(m, 1'b1, 1'b0, a, 32'h0);
        cyc(1);
        m_rs[m] = 1'b0;
        lat = -1;
        for (int c = 1; c < 80; c++) begin
            if (m_rdy[m]) begin
                lat = c;
                break;
            end
            if (c == 2) strobe(m, 1'b1, 1'b0, a ^ 32'h100, 32'h0);
            if (c == 3) m_rs[m] = 1'b0;
            cyc(1);
        end
    endtask

    task automatic test_reset();
        total++;
        if (m_rdy !== '1 || m_rdata !== '0 || tmo !== 1'b0 || act !== 2'(N-1)) begin
            bad++;
            $display("FAIL reset_up got rdy=%b rd=%h tmo=%b act=%0d want rdy=1111 rd=0 tmo=0 act=%0d",
                     m_rdy, m_rdata, tmo, act, N-1);
        end
        total++;
        if (s_addr !== '0 || s_wdata !== '0 || s_rs !== 1'b0 || s_ws !== 1'b0) begin
            bad++;
            $display("FAIL reset_down got addr=%h wd=%h rs=%b ws=%b want all 0", s_addr, s_wdata, s_rs, s_ws);
        end
        reset = 1'b1;
        cyc(2);
    endtask

    task automatic test_single_read();
        int lat;
        int ns0;
        bit ok;
        ns0 = n_strobe;
        do_read_lat(0, 32'h43C0_0004, lat);
        total++;
        if (lat != 5) begin
            bad++;
            $display("FAIL single_read_latency got=%0d want=5", lat);
        end
        total++;
        if (m_rdata[31:0] !== 32'h1234_5678) begin
            bad++;
            $display("FAIL single_read_data got=%h want=12345678", m_rdata[31:0]);
        end
        wait_quiet(50, ok);
        total++;
        if (!ok || n_strobe - ns0 != 1) begin
            bad++;
            $display("FAIL single_read_strobes got=%0d quiet=%b want=1", n_strobe - ns0, ok);
        end
    endtask

    task automatic test_wait_states();
        int lat;
        bit ok;
        slv_wait = 5;
        do_read_lat(1, 32'h2000_0010, lat);
        slv_wait = 0;
        total++;
        if (lat != 10) begin
            bad++;
            $display("FAIL wait_latency got=%0d want=10", lat);
        end
        total++;
        if (m_rdata[63:32] !== slv_data(32'h2000_0010)) begin
            bad++;
            $display("FAIL wait_data got=%h want=%h", m_rdata[63:32], slv_data(32'h2000_0010));
        end
        wait_quiet(50, ok);
    endtask

    task automatic test_contention();
        bit ok, acc0, acc1;
        do_reset();
        wseq.delete();
        push_exp(0, 32'h10, 32'hA, 1'b1);
        push_exp(1, 32'h10, 32'hB, 1'b1);
        push_exp(0, 32'h10, 32'hC, 1'b1);
        push_exp(1, 32'h10, 32'hD, 1'b1);
        strobe(0, 1'b0, 1'b1, 32'h10, 32'hA);
        strobe(1, 1'b0, 1'b1, 32'h10, 32'hB);
        cyc(1);
        m_ws = '0;
        acc0 = 1'b0;
        acc1 = 1'b0;
        // Each master re-requests the moment its ready returns.
        for (int c = 0; c < 100 && !(acc0 && acc1); c++) begin
            if (!acc0 && m_rdy[0]) begin strobe(0, 1'b0, 1'b1, 32'h10, 32'hC); acc0 = 1'b1; end
            else m_ws[0] = 1'b0;
            if (!acc1 && m_rdy[1]) begin strobe(1, 1'b0, 1'b1, 32'h10, 32'hD); acc1 = 1'b1; end
            else m_ws[1] = 1'b0;
            cyc(1);
        end
        m_ws = '0;
        wait_quiet(100, ok);
        total++;
        if (!ok || wseq.size() != 4 || wseq[0] !== 32'hA || wseq[1] !== 32'hB ||
            wseq[2] !== 32'hC || wseq[3] !== 32'hD) begin
            bad++;
            $display("FAIL contention_order got n=%0d quiet=%b want A,B,C,D", wseq.size(), ok);
        end
    endtask

    task automatic test_rw_both();
        bit ok;
        push_exp(2, 32'h20, 32'h77, 1'b1);
        strobe(2, 1'b1, 1'b1, 32'h20, 32'h77);
        cyc(1);
        m_rs = '0;
        m_ws = '0;
        wait_quiet(50, ok);
        total++;
        if (!ok || m_rdata[95:64] !== mdl_rd[2]) begin
            bad++;
            $display("FAIL rw_both got rd=%h quiet=%b want rd=%h", m_rdata[95:64], ok, mdl_rd[2]);
        end
    endtask

    task automatic test_fairness();
        int acc [N];
        bit ok, all_done;
        do_reset();
        gseq.delete();
        for (int m = 0; m < N; m++) begin svc[m] = 0; acc[m] = 0; end
        for (int k = 0; k < 40; k++) push_exp(k % N, 32'h100 + 32'(4 * (k % N)), 32'h5000 + 32'(k % N), 1'b1);
        all_done = 1'b0;
        for (int c = 0; c < 400 && !all_done; c++) begin
            for (int m = 0; m < N; m++) begin
                if (m_rdy[m] && acc[m] < 10) begin
                    strobe(m, 1'b0, 1'b1, 32'h100 + 32'(4 * m), 32'h5000 + 32'(m));
                    acc[m]++;
                end else begin
                    m_ws[m] = 1'b0;
                end
            end
            cyc(1);
            all_done = 1'b1;
            for (int m = 0; m < N; m++) if (acc[m] < 10) all_done = 1'b0;
        end
        m_ws = '0;
        wait_quiet(400, ok);
        for (int m = 0; m < N; m++) begin
            total++;
            if (svc[m] != 10) begin
                bad++;
                $display("FAIL fairness_count master=%0d got=%0d want=10", m, svc[m]);
            end
        end
        total++;
        ok = ok && (gseq.size() == 40);
        for (int k = 0; k < gseq.size(); k++) if (gseq[k] != k % N) ok = 1'b0;
        if (!ok) begin
            bad++;
            $display("FAIL fairness_rotation got n=%0d want 40 grants rotating 0..3", gseq.size());
        end
    endtask

    task automatic test_timeout();
        int t0;
        bit ok;
        t0 = n_tmo;
        push_exp(1, HANG_ADDR, 32'h0, 1'b0);
        push_exp(0, 32'h300, 32'h0, 1'b0);
        strobe(1, 1'b1, 1'b0, HANG_ADDR, 32'h0);
        cyc(1);
        m_rs = '0;
        cyc(3);
        strobe(0, 1'b1, 1'b0, 32'h300, 32'h0);
        cyc(1);
        m_rs = '0;
        wait_quiet(200, ok);
        total++;
        if (!ok || n_tmo - t0 != 1) begin
            bad++;
            $display("FAIL timeout_pulse got=%0d quiet=%b want=1", n_tmo - t0, ok);
        end
        total++;
        if (m_rdata[63:32] !== 32'hDEADBEEF || m_rdata[31:0] !== slv_data(32'h300)) begin
            bad++;
            $display("FAIL timeout_data got m1=%h m0=%h want m1=deadbeef m0=%h",
                     m_rdata[63:32], m_rdata[31:0], slv_data(32'h300));
        end
    endtask

    task automatic test_reset_mid();
        int ns0, lat;
        bit ok;
        slv_wait = 30;
        push_exp(0, 32'h400, 32'h0, 1'b0);
        push_exp(1, 32'h404, 32'h0, 1'b0);
        strobe(0, 1'b1, 1'b0, 32'h400, 32'h0);
        cyc(1);
        m_rs = '0;
        strobe(1, 1'b1, 1'b0, 32'h404, 32'h0);
        cyc(1);
        m_rs = '0;
        cyc(2);
        reset = 1'b0;
        #1;
        total++;
        if (m_rdy !== '1 || s_rs !== 1'b0 || s_ws !== 1'b0 || s_addr !== '0 ||
            m_rdata !== '0 || act !== 2'(N-1)) begin
            bad++;
            $display("FAIL reset_mid got rdy=%b rs=%b ws=%b addr=%h act=%0d want rdy=1111 all 0 act=%0d",
                     m_rdy, s_rs, s_ws, s_addr, act, N-1);
        end
        flush_model();
        slv_wait = 0;
        cyc(3);
        reset = 1'b1;
        ns0 = n_strobe;
        cyc(20);
        total++;
        if (n_strobe != ns0) begin
            bad++;
            $display("FAIL reset_no_reissue got=%0d strobes want=0", n_strobe - ns0);
        end
        do_read_lat(1, 32'h43C0_0004, lat);
        total++;
        if (lat != 5 || m_rdata[63:32] !== 32'h1234_5678) begin
            bad++;
            $display("FAIL reset_after got lat=%0d rd=%h want lat=5 rd=12345678", lat, m_rdata[63:32]);
        end
        wait_quiet(50, ok);
    endtask

    initial begin
        for (int m = 0; m < N; m++) begin mdl_rd[m] = '0; svc[m] = 0; end
        cyc(2);
        test_reset();
        test_single_read();
        test_wait_states();
        test_contention();
        test_rw_both();
        test_fairness();
        test_timeout();
        test_reset_mid();
        total++;
        if (sq.size() != 0 || cq.size() != 0) begin
            bad++;
            $display("FAIL leftover got sq=%0d cq=%0d want 0", sq.size(), cq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
